one_wire_tx_sequencer: RTL

- Byte-level transmit sequencer directly upstream of the 1-Wire write-bit slot generator.
- Buffers command/data bytes from the controller in a small FIFO and serialises each byte LSB first.
- Issues one write-slot request per bit and waits for that slot to complete before issuing the next.
- Reports per-byte and per-frame completion; supports abort without cutting an in-flight slot.

---
 rtl/one_wire_tx_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/one_wire_tx_sequencer.sv
// one_wire_tx_sequencer
//   Byte-level transmit sequencer feeding a 1-Wire write-bit slot generator.
//   Words from the controller are buffered in a small FIFO and each word is
//   serialised LSB first, one slot request per bit. The next slot is requested
//   only after the previous one reports completion. Abort flushes the FIFO but
//   lets an in-flight slot finish so the bus is never left mid-slot.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   s_valid/s_ready    upstream word handshake
//   s_data, s_last     word to send (LSB first) and end-of-frame flag
//   abort              single-cycle flush-and-stop request
//   bit_start          one-cycle slot request to the slot generator
//   bit_value          bit for the current slot, stable for the whole slot
//   bit_done           one-cycle slot-complete pulse from the slot generator
//   busy               sequencer active or FIFO non-empty
//   byte_sent          pulse: last bit of a word completed
//   frame_done         pulse: last bit of an s_last word completed
//   aborted            pulse: abort sequence finished
//   fifo_count         current FIFO occupancy
module one_wire_tx_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WORD_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [WORD_W-1:0]             s_data,
  input  logic                          s_last,
  input  logic                          abort,
  output logic                          bit_start,
  output logic                          bit_value,
  input  logic                          bit_done,
  output logic                          busy,
  output logic                          byte_sent,
  output logic                          frame_done,
  output logic                          aborted,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BIT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StFlush
  } state_t;

  state_t                r_state;
  logic [WORD_W-1:0]     r_mem [FIFO_DEPTH];
  logic                  r_last_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic [WORD_W-1:0]     r_shreg;
  logic                  r_sh_last;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic                  r_bit_start;
  logic                  r_byte_sent;
  logic                  r_frame_done;
  logic                  r_aborted;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_clear;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // No full-bypass: a pop in the same cycle does not reopen a full FIFO.
  assign s_ready = !w_full && (r_state != StFlush) && !abort;
  assign w_push  = s_valid && s_ready;
  // Abort takes priority over loading the next word.
  assign w_pop   = (r_state == StIdle) && !w_empty && !abort;
  assign w_clear = abort && (r_state != StFlush);

  assign bit_start  = r_bit_start;
  assign bit_value  = r_shreg[0];
  assign byte_sent  = r_byte_sent;
  assign frame_done = r_frame_done;
  assign aborted    = r_aborted;
  assign fifo_count = r_count;
  // Pulse terms keep busy high through the completion pulse so it falls one cycle later.
  assign busy = (r_state != StIdle) || !w_empty || r_byte_sent || r_aborted;

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr]      <= s_data;
      r_last_mem[r_wptr] <= s_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_shreg      <= '0;
      r_sh_last    <= 1'b0;
      r_bit_cnt    <= '0;
      r_bit_start  <= 1'b0;
      r_byte_sent  <= 1'b0;
      r_frame_done <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_bit_start  <= 1'b0;
      r_byte_sent  <= 1'b0;
      r_frame_done <= 1'b0;
      r_aborted    <= 1'b0;

      // FIFO bookkeeping; clear and push never coincide since abort drops s_ready.
      if (w_clear) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
        if (w_push && !w_pop) begin
          r_count <= r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
          r_count <= r_count - CNT_W'(1);
        end
      end

      unique case (r_state)
        StIdle: begin
          if (abort) begin
            r_aborted <= 1'b1;
          end else if (!w_empty) begin
            r_shreg     <= r_mem[r_rptr];
            r_sh_last   <= r_last_mem[r_rptr];
            r_bit_cnt   <= '0;
            r_bit_start <= 1'b1;
            r_state     <= StIssue;
          end
        end
        StIssue: begin
          // bit_done here is spurious and ignored; the slot has only just been requested.
          r_state <= abort ? StFlush : StWaitDone;
        end
        StWaitDone: begin
          if (bit_done) begin
            if (abort) begin
              // Completing slot is the final one; partial word is dropped silently.
              r_aborted <= 1'b1;
              r_state   <= StIdle;
            end else if (r_bit_cnt < BIT_W'(WORD_W - 1)) begin
              r_shreg     <= {1'b0, r_shreg[WORD_W-1:1]};
              r_bit_cnt   <= r_bit_cnt + BIT_W'(1);
              r_bit_start <= 1'b1;
              r_state     <= StIssue;
            end else begin
              r_byte_sent  <= 1'b1;
              r_frame_done <= r_sh_last;
              r_state      <= StIdle;
            end
          end else if (abort) begin
            r_state <= StFlush;
          end
        end
        StFlush: begin
          if (bit_done) begin
            r_aborted <= 1'b1;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
